// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Session controller for the whack-a-mole timebase. It sequences a round
// through IDLE -> RUN <-> PAUSE -> OVER and owns the one-second countdown, the
// score and the level. It also produces the TimeExpire value and the
// active-low reset for the mole-rate clock divider. The mole rate doubles on
// each level-up.
//
// Parameters
//   TICK_CYCLES    clk cycles per game second (>= 2)
//   GAME_SECONDS   round length in seconds (1..255)
//   HITS_PER_LEVEL hits needed per level advance (1..255)
//   BASE_EXPIRE    divider TimeExpire value at level 0
//
// Ports
//   clk          system clock
//   rst          synchronous, active-low reset
//   start        level; begins a round from IDLE or restarts it from OVER
//   pause        level; freezes the round while high
//   hit          one-cycle pulse per successful whack
//   running      high in RUN; active-low reset of the mole divider
//   time_expire  BASE_EXPIRE >> level, one cycle behind level
//   sec_tick     one-cycle pulse per elapsed game second
//   time_left    seconds remaining in the round
//   level        current level, 0..3
//   score        hit count, saturating at 999
//   game_over    high in OVER
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int TICK_CYCLES    = 50_000_000,
  parameter int GAME_SECONDS   = 60,
  parameter int HITS_PER_LEVEL = 10,
  parameter int BASE_EXPIRE    = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        hit,
  output logic        running,
  output logic [31:0] time_expire,
  output logic        sec_tick,
  output logic [7:0]  time_left,
  output logic [1:0]  level,
  output logic [9:0]  score,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int          PW         = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]  SECS_INIT  = 8'(GAME_SECONDS);
  localparam logic [7:0]  HIT_LAST   = 8'(HITS_PER_LEVEL - 1);
  localparam logic [9:0]  SCORE_MAX  = 10'd999;
  localparam logic [31:0] BASE32     = 32'(BASE_EXPIRE);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      hit_cnt_q, hit_cnt_d;
  logic [7:0]      time_left_d;
  logic [1:0]      level_d;
  logic [9:0]      score_d;
  logic [31:0]     expire_d;
  logic            sec_tick_d;

  // A RUN cycle that is not frozen by pause advances the timebase. Both
  // processes below use this so that pause keeps its priority over tick and hit.
  logic run_active;
  logic tick_now;
  logic last_tick;

  assign run_active = (state_q == RUN) && !pause;
  assign tick_now   = run_active && (presc_q == PRESC_MAX);
  assign last_tick  = tick_now && (time_left == 8'd1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (pause)          state_d = PAUSE;
        else if (last_tick) state_d = OVER;
      end
      PAUSE:   if (!pause) state_d = RUN;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d     = presc_q;
    hit_cnt_d   = hit_cnt_q;
    time_left_d = time_left;
    level_d     = level;
    score_d     = score;
    sec_tick_d  = 1'b0;
    // The divider value trails level by one cycle.
    expire_d    = BASE32 >> level;

    case (state_q)
      IDLE, OVER: begin
        // Starting a round reloads everything reset would set.
        if (start) begin
          presc_d     = '0;
          hit_cnt_d   = '0;
          time_left_d = SECS_INIT;
          level_d     = 2'd0;
          score_d     = 10'd0;
          expire_d    = BASE32;
        end
      end
      RUN: begin
        if (run_active) begin
          if (tick_now) begin
            presc_d     = '0;
            sec_tick_d  = 1'b1;
            time_left_d = time_left - 8'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end

          // A hit in the same cycle as a tick (including the final one) is
          // still counted.
          if (hit) begin
            if (score != SCORE_MAX) score_d = score + 10'd1;
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d = '0;
              if (level != 2'd3) level_d = level + 2'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + 8'd1;
            end
          end
        end
      end
      default: ;  // PAUSE: everything holds
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is control state with a defined restart value,
  // so all of them take the synchronous reset (there is no storage array that
  // could be left unreset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q     <= '0;
      hit_cnt_q   <= '0;
      time_left   <= SECS_INIT;
      level       <= 2'd0;
      score       <= 10'd0;
      time_expire <= BASE32;
      sec_tick    <= 1'b0;
      running     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hit_cnt_q   <= hit_cnt_d;
      time_left   <= time_left_d;
      level       <= level_d;
      score       <= score_d;
      time_expire <= expire_d;
      sec_tick    <= sec_tick_d;
      running     <= (state_d == RUN);
      game_over   <= (state_d == OVER);
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_timer_ctrl
//
// Directed bench for game_timer_ctrl with TICK_CYCLES=4, GAME_SECONDS=3,
// HITS_PER_LEVEL=2 and BASE_EXPIRE=64. A per-cycle vector table covers reset,
// start, ticks, levelling, the final-tick hit, OVER, restart and mid-round
// reset. Hand sequences cover pause and score saturation. A second instance
// with GAME_SECONDS=255 is used for the saturation run.
// Inputs change on the falling edge; outputs are compared on the next falling
// edge, after the intervening rising edge.
// -----------------------------------------------------------------------------
module tb_game_timer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        rst, start, pause, hit;
  logic        running, sec_tick, game_over;
  logic [31:0] time_expire;
  logic [7:0]  time_left;
  logic [1:0]  level;
  logic [9:0]  score;

  // Saturation instance
  logic        s_rst, s_start, s_pause, s_hit;
  logic        s_running, s_sec_tick, s_game_over;
  logic [31:0] s_time_expire;
  logic [7:0]  s_time_left;
  logic [1:0]  s_level;
  logic [9:0]  s_score;

  game_timer_ctrl #(
    .TICK_CYCLES(4), .GAME_SECONDS(3), .HITS_PER_LEVEL(2), .BASE_EXPIRE(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit),
    .running(running), .time_expire(time_expire), .sec_tick(sec_tick),
    .time_left(time_left), .level(level), .score(score), .game_over(game_over)
  );

  game_timer_ctrl #(
    .TICK_CYCLES(4), .GAME_SECONDS(255), .HITS_PER_LEVEL(2), .BASE_EXPIRE(64)
  ) dut_sat (
    .clk(clk), .rst(s_rst), .start(s_start), .pause(s_pause), .hit(s_hit),
    .running(s_running), .time_expire(s_time_expire), .sec_tick(s_sec_tick),
    .time_left(s_time_left), .level(s_level), .score(s_score),
    .game_over(s_game_over)
  );

  typedef struct {
    logic        rst, start, pause, hit;
    logic        running, sec_tick, game_over;
    logic [7:0]  time_left;
    logic [1:0]  level;
    logic [9:0]  score;
    logic [31:0] time_expire;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, s, p, h,
                              input logic ru, tk, go,
                              input int tl, lv, sc, te);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p; v.hit = h;
    v.running = ru; v.sec_tick = tk; v.game_over = go;
    v.time_left = 8'(tl); v.level = 2'(lv); v.score = 10'(sc);
    v.time_expire = 32'(te);
    return v;
  endfunction

  task automatic check_main(input string tag, input logic ru, tk, go,
                            input int tl, lv, sc, te);
    check({tag, ".running"},     32'(running),   32'(ru));
    check({tag, ".sec_tick"},    32'(sec_tick),  32'(tk));
    check({tag, ".game_over"},   32'(game_over), 32'(go));
    check({tag, ".time_left"},   32'(time_left), 32'(tl));
    check({tag, ".level"},       32'(level),     32'(lv));
    check({tag, ".score"},       32'(score),     32'(sc));
    check({tag, ".time_expire"}, time_expire,    32'(te));
  endtask

  // Watchdog: the run is a fixed number of cycles, so this only trips on a
  // broken simulation.
  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               rst st pa hi | run tk go  tl lv sc  te
    vecs[0]  = mk(0, 0, 0, 0,   0, 0, 0,  3, 0, 0, 64);  // reset
    vecs[1]  = mk(0, 0, 0, 0,   0, 0, 0,  3, 0, 0, 64);
    vecs[2]  = mk(0, 0, 0, 0,   0, 0, 0,  3, 0, 0, 64);
    vecs[3]  = mk(1, 0, 0, 0,   0, 0, 0,  3, 0, 0, 64);  // IDLE holds
    vecs[4]  = mk(1, 1, 0, 0,   1, 0, 0,  3, 0, 0, 64);  // RUN entry, presc 0
    vecs[5]  = mk(1, 0, 0, 1,   1, 0, 0,  3, 0, 1, 64);
    vecs[6]  = mk(1, 0, 0, 1,   1, 0, 0,  3, 1, 2, 64);  // level 1
    vecs[7]  = mk(1, 0, 0, 0,   1, 0, 0,  3, 1, 2, 32);  // expire lags level
    vecs[8]  = mk(1, 0, 0, 1,   1, 1, 0,  2, 1, 3, 32);  // tick 1 with hit
    vecs[9]  = mk(1, 0, 0, 1,   1, 0, 0,  2, 2, 4, 32);  // level 2
    vecs[10] = mk(1, 0, 0, 1,   1, 0, 0,  2, 2, 5, 16);
    vecs[11] = mk(1, 0, 0, 1,   1, 0, 0,  2, 3, 6, 16);  // level 3
    vecs[12] = mk(1, 0, 0, 1,   1, 1, 0,  1, 3, 7, 8);   // tick 2
    vecs[13] = mk(1, 0, 0, 1,   1, 0, 0,  1, 3, 8, 8);   // level stays 3
    vecs[14] = mk(1, 0, 0, 0,   1, 0, 0,  1, 3, 8, 8);
    vecs[15] = mk(1, 0, 0, 0,   1, 0, 0,  1, 3, 8, 8);
    vecs[16] = mk(1, 0, 0, 1,   0, 1, 1,  0, 3, 9, 8);   // final tick + hit
    vecs[17] = mk(1, 0, 0, 1,   0, 0, 1,  0, 3, 9, 8);   // hit ignored in OVER
    vecs[18] = mk(1, 0, 1, 0,   0, 0, 1,  0, 3, 9, 8);   // pause ignored in OVER
    vecs[19] = mk(1, 1, 0, 0,   1, 0, 0,  3, 0, 0, 64);  // restart
    vecs[20] = mk(1, 0, 0, 0,   1, 0, 0,  3, 0, 0, 64);
    vecs[21] = mk(1, 0, 0, 0,   1, 0, 0,  3, 0, 0, 64);
    vecs[22] = mk(0, 1, 0, 0,   0, 0, 0,  3, 0, 0, 64);  // reset beats start
    vecs[23] = mk(1, 1, 0, 0,   1, 0, 0,  3, 0, 0, 64);  // RUN, presc 0
    vecs[24] = mk(1, 0, 0, 0,   1, 0, 0,  3, 0, 0, 64);
    vecs[25] = mk(1, 1, 0, 0,   1, 0, 0,  3, 0, 0, 64);  // start ignored in RUN
    vecs[26] = mk(1, 0, 0, 0,   1, 0, 0,  3, 0, 0, 64);
    vecs[27] = mk(1, 0, 0, 0,   1, 1, 0,  2, 0, 0, 64);  // full 4 cycles

    rst = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0;
    s_rst = 1'b0; s_start = 1'b0; s_pause = 1'b0; s_hit = 1'b0;
    @(negedge clk);

    // ---- Table-driven main sequence ----
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; start = vecs[i].start;
      pause = vecs[i].pause; hit = vecs[i].hit;
      @(negedge clk);
      check_main($sformatf("v%0d", i), vecs[i].running, vecs[i].sec_tick,
                 vecs[i].game_over, int'(vecs[i].time_left),
                 int'(vecs[i].level), int'(vecs[i].score),
                 int'(vecs[i].time_expire));
    end
    rst = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0;

    // ---- Pause freeze: prescaler currently 0, time_left 2 ----
    @(negedge clk);                                   // presc 1
    @(negedge clk);                                   // presc 2
    check_main("pz.pre", 1, 0, 0, 2, 0, 0, 64);
    for (int i = 0; i < 10; i++) begin
      pause = 1'b1;
      hit   = (i % 2 == 0);                           // hit on the first cycle too
      @(negedge clk);
      check_main($sformatf("pz%0d", i), 0, 0, 0, 2, 0, 0, 64);
    end
    pause = 1'b0; hit = 1'b0;
    @(negedge clk);                                   // back in RUN, presc 2
    check_main("pz.rel", 1, 0, 0, 2, 0, 0, 64);
    @(negedge clk);                                   // presc 3
    check("pz.run1.sec_tick", 32'(sec_tick), 32'd0);
    @(negedge clk);                                   // wrap
    check("pz.run2.sec_tick", 32'(sec_tick), 32'd1);
    check("pz.run2.time_left", 32'(time_left), 32'd1);

    // ---- Score saturation on the long-round instance ----
    s_rst = 1'b1; s_start = 1'b1;
    @(negedge clk);
    check("sat.running", 32'(s_running), 32'd1);
    check("sat.score0", 32'(s_score), 32'd0);
    s_start = 1'b0; s_hit = 1'b1;
    for (int i = 1; i <= 1005; i++) begin
      @(negedge clk);
      if (i == 998) check("sat.score998", 32'(s_score), 32'd998);
      if (i == 999) check("sat.score999", 32'(s_score), 32'd999);
    end
    s_hit = 1'b0;
    check("sat.score_end", 32'(s_score), 32'd999);
    check("sat.level", 32'(s_level), 32'd3);
    check("sat.game_over", 32'(s_game_over), 32'd0);
    check("sat.time_expire", s_time_expire, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
